i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
// - I2C target (responder) paired with the on-chip sequenced I2C initiator: decodes
//   START/addr/pointer/data on SCL/SDA, ACKs, writes an internal register file.
// - Used as a loopback stand-in for the codec target in system sims and on-board
//   self-test; the initiator's bytes can be read back by the host logic.
// - Open-drain style: sda_o tied 0, sda_t=1 releases the line, sda_t=0 pulls low.
// PARAMETERS
// - DEV_ADDR  7'h3B  7-bit target address matched against first byte[7:1]
// - REG_AW    4      register index width; file depth = 2**REG_AW bytes
// - RST_VAL   8'h00  reset value of every register-file entry
// PORTS
// - clk         in   1       system clock (oversamples SCL, >=8x SCL rate)
// - rst         in   1       synchronous, active-high reset
// - i2c_scl_i   in   1       SCL from pad (asynchronous)
// - i2c_sda_i   in   1       SDA from pad (asynchronous)
// - i2c_sda_o   out  1       SDA output value, constant 0
// - i2c_sda_t   out  1       SDA tristate: 1=release, 0=drive low
// - host_raddr  in   REG_AW  host-side read index
// - host_rdata  out  8       regfile[host_raddr], registered, 1-cycle latency
// - wr_stb      out  1       1-cycle pulse per register written over I2C
// - wr_idx      out  REG_AW  index of that write (valid with wr_stb)
// - wr_data     out  8       data of that write (valid with wr_stb)
// - busy        out  1       1 from START to STOP of an addressed transaction
// BEHAVIOUR
// - Reset: sda_t=1, sda_o=0, wr_stb=0, wr_idx=0, wr_data=0, busy=0, host_rdata=0,
//   pointer=0, all regs=RST_VAL, state=IDLE. Reset mid-transfer releases SDA at once.
// - SCL/SDA pass 2-flop syncs + 1 history flop; edges detected on synced copies.
// - START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both override any
//   state (repeated START -> ADDR, bit count cleared; STOP -> IDLE, sda_t=1, busy=0).
// - Data sampled on SCL rise; SDA changed only on the cycle after SCL fall is seen.
// - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK,
//   IGNORE. Bit counter 0..7, MSB first.
// - ADDR: after 8 bits, if byte[7:1]==DEV_ADDR -> drive ACK (sda_t=0) for the 9th
//   clock, busy=1; else -> IGNORE (sda_t stays 1) until next START/STOP.
// - ADDR_ACK: release SDA on the SCL fall ending the 9th clock; R/W=0 -> PTR,
//   R/W=1 -> RDATA (see CONFIGURATION).
// - PTR: first write byte loads pointer <= byte[REG_AW-1:0]; ACK; -> WDATA.
// - WDATA: each byte ACKed, regfile[pointer] <= byte, wr_stb pulses one cycle on
//   the SCL rise of bit 0 with wr_idx=pointer, wr_data=byte; pointer+1 mod 2**REG_AW.
// - RDATA: drive regfile[pointer] MSB first (sda_t=~bit); after 8th bit release,
//   pointer+1 mod depth; sample master ACK on 9th SCL rise: ACK(0) -> RDATA, NACK(1)
//   -> IGNORE until STOP/START.
// - host_rdata reads the same array; an I2C write and host read of one index in the
//   same cycle returns the old value.
// - Pointer persists across transactions (write-pointer then repeated-START read).
// CONFIGURATION
// - I2C_READ_EN defined: read path (RDATA/RDATA_ACK) compiled in, R/W=1 ACKed.
// - I2C_READ_EN undefined: R/W=1 with matching address is NACKed, -> IGNORE;
//   RDATA/RDATA_ACK logic absent; write path unchanged.
// TESTING
// - Write 0x76,0x05,0xA5,STOP -> ACK x3, wr_stb once idx=5 data=A5, host_rdata[5]=A5.
// - Write 0x72(addr 0x39),0x00 -> address NACK, sda_t stays 1, no wr_stb, busy=0.
// - Burst 0x76,0x0F,0x11,0x22 (REG_AW=4) -> reg[15]=11, reg[0]=22 (pointer wraps).
// - I2C_READ_EN: 0x76,0x03, rSTART,0x77, read 2 (ACK,NACK) -> bytes reg[3],reg[4].
// - No I2C_READ_EN: 0x77 -> 9th-clock SDA high (NACK), no drive on following bytes.
// - rst asserted mid-data-byte while sda_t=0 -> sda_t=1 next cycle, all regs=RST_VAL.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (responder) that decodes START/address/pointer/data
// from oversampled SCL/SDA, ACKs its own address and writes a byte register file.
// The host side reads the same array through a registered port.
// Optional feature: define I2C_READ_EN to build the I2C read path (RDATA/RDATA_ACK);
// without it a matching address with R/W=1 is NACKed and the target goes quiet.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h3B,
  parameter int         REG_AW   = 4,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_scl_i,
  input  logic              i2c_sda_i,
  output logic              i2c_sda_o,
  output logic              i2c_sda_t,
  input  logic [REG_AW-1:0] host_raddr,
  output logic [7:0]        host_rdata,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_idx,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << REG_AW;
`ifdef I2C_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              scl_p0, scl_p1, scl_p2;
  logic              sda_p0, sda_p1, sda_p2;
  logic              scl_rise, scl_fall, start_cond, stop_cond;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        byte_in;
  logic              addr_ack;
  logic [REG_AW-1:0] pointer;
  logic              sda_t_q;
  logic              sda_t_nxt;
  logic [7:0]        regfile [DEPTH];
`ifdef I2C_READ_EN
  logic [7:0]        tx;
  logic              master_ack;
`endif

  // p0/p1: two-flop synchroniser; p2: one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= i2c_scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= i2c_sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_cond  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_in    = {shift[6:0], sda_p1};
  assign addr_ack   = (shift[7:1] == DEV_ADDR) && (!shift[0] || RD_EN);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: START/STOP override everything, byte phases advance on SCL fall
  always_comb begin
    state_nxt = state;
    if (start_cond) begin
      state_nxt = ADDR;
    end else if (stop_cond) begin
      state_nxt = IDLE;
    end else if (scl_fall) begin
      case (state)
        ADDR:      if (bit_cnt == 4'd8) state_nxt = addr_ack ? ADDR_ACK : IGNORE;
`ifdef I2C_READ_EN
        ADDR_ACK:  state_nxt = shift[0] ? RDATA : PTR;
`else
        ADDR_ACK:  state_nxt = PTR;
`endif
        PTR:       if (bit_cnt == 4'd8) state_nxt = PTR_ACK;
        PTR_ACK:   state_nxt = WDATA;
        WDATA:     if (bit_cnt == 4'd8) state_nxt = WDATA_ACK;
        WDATA_ACK: state_nxt = WDATA;
`ifdef I2C_READ_EN
        RDATA:     if (bit_cnt == 4'd8) state_nxt = RDATA_ACK;
        RDATA_ACK: state_nxt = master_ack ? RDATA : IGNORE;
`endif
        default:   state_nxt = state;
      endcase
    end
  end

  // SDA drive decision; only changes on a seen SCL fall (or START/STOP release)
  always_comb begin
    sda_t_nxt = sda_t_q;
    if (start_cond || stop_cond) begin
      sda_t_nxt = 1'b1;
    end else if (scl_fall) begin
      case (state)
        ADDR:               if (bit_cnt == 4'd8) sda_t_nxt = ~addr_ack;
        PTR, WDATA:         if (bit_cnt == 4'd8) sda_t_nxt = 1'b0;
`ifdef I2C_READ_EN
        ADDR_ACK:           sda_t_nxt = shift[0] ? ~regfile[pointer][7] : 1'b1;
        RDATA:              sda_t_nxt = (bit_cnt == 4'd8) ? 1'b1 : ~tx[6];
        RDATA_ACK:          sda_t_nxt = master_ack ? ~regfile[pointer][7] : 1'b1;
`endif
        default:            sda_t_nxt = 1'b1;
      endcase
    end
  end

  // bit counting, shifting, pointer, register-file writes and write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      shift   <= 8'd0;
      pointer <= '0;
      sda_t_q <= 1'b1;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= 8'd0;
`ifdef I2C_READ_EN
      tx         <= 8'd0;
      master_ack <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) regfile[i] <= RST_VAL;
    end else begin
      wr_stb  <= 1'b0;
      sda_t_q <= sda_t_nxt;
      if (start_cond) begin
        bit_cnt <= 4'd0;
      end else if (stop_cond) begin
        bit_cnt <= 4'd0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (bit_cnt < 4'd8) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == WDATA && bit_cnt == 4'd7) begin
              regfile[pointer] <= byte_in;
              wr_stb           <= 1'b1;
              wr_idx           <= pointer;
              wr_data          <= byte_in;
              pointer          <= pointer + REG_AW'(1);
            end
          end
`ifdef I2C_READ_EN
          RDATA:     bit_cnt <= bit_cnt + 4'd1;
          RDATA_ACK: master_ack <= ~sda_p1;
`endif
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (addr_ack) busy <= 1'b1;
            end
          end
          PTR: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              pointer <= shift[REG_AW-1:0];
            end
          end
          WDATA:     if (bit_cnt == 4'd8) bit_cnt <= 4'd0;
`ifdef I2C_READ_EN
          ADDR_ACK: begin
            if (shift[0]) begin
              tx      <= regfile[pointer];
              bit_cnt <= 4'd0;
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              pointer <= pointer + REG_AW'(1);
            end else begin
              tx <= {tx[6:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            if (master_ack) begin
              tx      <= regfile[pointer];
              bit_cnt <= 4'd0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // host read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) host_rdata <= 8'd0;
    else     host_rdata <= regfile[host_raddr];
  end

  assign i2c_sda_o = 1'b0;
  assign i2c_sda_t = sda_t_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C initiator driving i2c_target_regs, with a
// byte-array reference model and a scoreboard monitor doing all comparisons.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam logic [6:0] DEV = 7'h3B;
  localparam int         AW  = 4;
  localparam int         Q   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic [AW-1:0] host_raddr = '0;
  logic [7:0]    host_rdata;
  logic          i2c_sda_o, i2c_sda_t;
  logic          wr_stb, busy;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;

  assign sda_line = sda_m & (i2c_sda_t | i2c_sda_o);

  i2c_target_regs #(.DEV_ADDR(DEV), .REG_AW(AW), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .i2c_scl_i(scl_m), .i2c_sda_i(sda_line),
    .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t), .host_raddr(host_raddr),
    .host_rdata(host_rdata), .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // scoreboard queues
  string        name_q[$];
  int unsigned  exp_q[$];
  int unsigned  obs_q[$];
  logic [11:0]  exp_wr_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           end_req = 0;
  bit           fin_done = 0;
  int           drive_cnt = 0;

  // reference model
  logic [7:0]   m_mem [16];
  logic [3:0]   m_ptr;
  logic [7:0]   txn[$];

  task automatic post(input string nm, input int unsigned e, input int unsigned a);
    name_q.push_back(nm);
    exp_q.push_back(e);
    obs_q.push_back(a);
  endtask

  // monitor: consumes write strobes and posted observations, sole owner of counts
  always @(negedge clk) begin
    if (!i2c_sda_t) drive_cnt++;
    if (wr_stb) begin
      n_tests++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_stb_unexpected: got idx=%0d data=%02h, required no write", wr_idx, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_wr_q.pop_front();
        if ({wr_idx, wr_data} !== e) begin
          n_fail++;
          $display("FAIL wr_stb: got idx=%0d data=%02h, required idx=%0d data=%02h",
                   wr_idx, wr_data, e[11:8], e[7:0]);
        end
      end
    end
    while (obs_q.size() > 0) begin
      string nm;
      int unsigned e, a;
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      a  = obs_q.pop_front();
      n_tests++;
      if (e !== a) begin
        n_fail++;
        $display("FAIL %s: got %0h, required %0h", nm, a, e);
      end
    end
    if (end_req && !fin_done) begin
      n_tests++;
      if (exp_wr_q.size() != 0) begin
        n_fail++;
        $display("FAIL wr_stb_missing: got %0d pending, required 0", exp_wr_q.size());
      end
      fin_done = 1;
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_bits(b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q();
      scl_m = 1'b1; wait_q();
      d[i] = sda_line; wait_q();
      scl_m = 1'b0;
    end
    wait_q();
    sda_m = ack_bit; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  // sends txn[] as one write transaction; the model decides ACKs and writes
  task automatic run_write_txn(input bit use_start, input bit use_stop);
    bit matched;
    logic got;
    if (use_start) i2c_start(); else i2c_rstart();
    matched = (txn[0][7:1] == DEV) && (txn[0][0] == 1'b0);
    for (int i = 0; i < txn.size(); i++) begin
      if (matched && i == 1) begin
        m_ptr = txn[1][3:0];
      end else if (matched && i >= 2) begin
        m_mem[m_ptr] = txn[i];
        exp_wr_q.push_back({m_ptr, txn[i]});
        m_ptr = m_ptr + 4'd1;
      end
      write_byte(txn[i], got);
      post($sformatf("ack_byte%0d_%02h", i, txn[i]), matched ? 0 : 1, got);
      if (i == 0) post("busy_mid", matched, busy);
    end
    if (use_stop) begin
      i2c_stop();
      post("busy_after_stop", 0, busy);
    end
  endtask

  task automatic check_reg(input int i);
    @(negedge clk) host_raddr = AW'(i);
    @(negedge clk) post($sformatf("reg%0d", i), m_mem[i], host_rdata);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 16; i++) check_reg(i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before 900000ns");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       got;
    int         snap;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 4'd0;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post("rst_sda_t", 1, i2c_sda_t);
    post("rst_sda_o", 0, i2c_sda_o);
    post("rst_busy", 0, busy);
    post("rst_wr_stb", 0, wr_stb);
    post("rst_wr_idx", 0, wr_idx);
    post("rst_wr_data", 0, wr_data);
    post("rst_host_rdata", 0, host_rdata);
    check_reg(7);

    // single write to register 5
    txn = '{8'h76, 8'h05, 8'hA5};
    run_write_txn(1, 1);
    check_reg(5);

    // wrong address: NACK, no drive, no write
    snap = drive_cnt;
    txn = '{8'h72, 8'h00};
    run_write_txn(1, 1);
    post("nack_no_drive", 0, drive_cnt - snap);

    // burst wrapping the pointer from 15 to 0
    txn = '{8'h76, 8'h0F, 8'h11, 8'h22};
    run_write_txn(1, 1);
    check_reg(15);
    check_reg(0);

`ifdef I2C_READ_EN
    txn = '{8'h76, 8'h03, 8'hC3, 8'h5A};
    run_write_txn(1, 1);
    txn = '{8'h76, 8'h03};
    run_write_txn(1, 0);
    i2c_rstart();
    write_byte(8'h77, got);
    post("rd_addr_ack", 0, got);
    read_byte(1'b0, d);
    post("rd_byte0", m_mem[m_ptr], d);
    m_ptr = m_ptr + 4'd1;
    read_byte(1'b1, d);
    post("rd_byte1", m_mem[m_ptr], d);
    m_ptr = m_ptr + 4'd1;
    i2c_stop();
    post("rd_busy_after_stop", 0, busy);
`else
    i2c_start();
    write_byte(8'h77, got);
    post("rd_addr_nack", 1, got);
    snap = drive_cnt;
    read_byte(1'b1, d);
    post("rd_ignored_byte", 8'hFF, d);
    post("rd_no_drive", 0, drive_cnt - snap);
    i2c_stop();
    post("rd_busy", 0, busy);
`endif

    // randomized write traffic, some to foreign addresses
    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      int         n;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV;
      txn.delete();
      txn.push_back({a, 1'b0});
      txn.push_back(8'($urandom));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) txn.push_back(8'($urandom));
      run_write_txn(1, 1);
    end
    check_all_regs();

    // reset in the ACK slot of a data byte while SDA is held low
    txn = '{8'h76, 8'h02};
    run_write_txn(1, 0);
    exp_wr_q.push_back({4'd2, 8'h99});
    write_bits(8'h99);
    repeat (3) @(negedge clk);
    post("ack_drive_before_rst", 0, i2c_sda_t);
    rst = 1'b1;
    @(negedge clk);
    post("sda_released_by_rst", 1, i2c_sda_t);
    post("busy_cleared_by_rst", 0, busy);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 4'd0;
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    check_all_regs();

    end_req = 1;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
